// File: rtl/imm_decode_queue.sv
// imm_decode_queue: instruction buffer that decodes RV format and immediate at enqueue.
// Optional full-stall counter is built only when IMM_QUEUE_PERF_EN is defined.
module imm_decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_instr,
    input  logic [XLEN-1:0]         in_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_instr,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_imm,
    output logic [2:0]              out_fmt,
    output logic                    out_illegal,
    output logic [$clog2(DEPTH):0]  count,
    output logic [31:0]             stall_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;

    logic [31:0]            instr_mem_q [DEPTH];
    logic [XLEN-1:0]        pc_mem_q    [DEPTH];
    logic signed [XLEN-1:0] imm_mem_q   [DEPTH];
    logic [2:0]             fmt_mem_q   [DEPTH];
    logic [DEPTH-1:0]       ill_mem_q;

    logic                   push, pop;
    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic signed [XLEN-1:0] dec_imm;
    logic [2:0]             dec_fmt;
    logic                   dec_ill;

    function automatic logic signed [XLEN-1:0] sext12(input logic signed [11:0] f);
        return XLEN'(f);
    endfunction

    function automatic logic signed [XLEN-1:0] sext13(input logic signed [12:0] f);
        return XLEN'(f);
    endfunction

    function automatic logic signed [XLEN-1:0] sext21(input logic signed [20:0] f);
        return XLEN'(f);
    endfunction

    function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] f);
        return XLEN'(f);
    endfunction

    // Shift amounts are unsigned; RV64 uses one extra shamt bit.
    function automatic logic signed [XLEN-1:0] shamt(input logic [31:0] ins);
        if (XLEN == 64) return XLEN'(ins[25:20]);
        else            return XLEN'(ins[24:20]);
    endfunction

    assign in_ready  = (count_q < FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign opcode    = in_instr[6:0];
    assign funct3    = in_instr[14:12];

    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_R;
        dec_ill = 1'b0;
        case (opcode)
            7'b0010011: begin
                dec_fmt = FMT_I;
                if (funct3 == 3'b001 || funct3 == 3'b101) dec_imm = shamt(in_instr);
                else                                      dec_imm = sext12($signed(in_instr[31:20]));
            end
            7'b0000011, 7'b1100111, 7'b1110011: begin
                dec_fmt = FMT_I;
                dec_imm = sext12($signed(in_instr[31:20]));
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                dec_imm = sext12($signed({in_instr[31:25], in_instr[11:7]}));
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                dec_imm = sext13($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                          in_instr[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                dec_imm = sext32($signed({in_instr[31:12], 12'b0}));
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                dec_imm = sext21($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                          in_instr[30:21], 1'b0}));
            end
            7'b0110011: dec_fmt = FMT_R;
            default:    dec_ill = 1'b1;
        endcase
    end

    // Flush wins over any push/pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            instr_mem_q[wr_ptr_q] <= in_instr;
            pc_mem_q[wr_ptr_q]    <= in_pc;
            imm_mem_q[wr_ptr_q]   <= dec_imm;
            fmt_mem_q[wr_ptr_q]   <= dec_fmt;
            ill_mem_q[wr_ptr_q]   <= dec_ill;
        end
    end

    assign out_instr   = instr_mem_q[rd_ptr_q];
    assign out_pc      = pc_mem_q[rd_ptr_q];
    assign out_imm     = imm_mem_q[rd_ptr_q];
    assign out_fmt     = fmt_mem_q[rd_ptr_q];
    assign out_illegal = ill_mem_q[rd_ptr_q];
    assign count       = count_q;

`ifdef IMM_QUEUE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && !flush && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_decode_queue.sv
// Self-checking bench for imm_decode_queue: directed format vectors plus randomized traffic
// against a queue-based reference model.
module tb_imm_decode_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef IMM_QUEUE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [31:0]     in_instr = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic            in_ready, out_valid, out_illegal;
    logic [31:0]     out_instr, stall_cnt;
    logic [XLEN-1:0] out_pc, out_imm;
    logic [2:0]      out_fmt;
    logic [CW-1:0]   count;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } entry_t;

    entry_t  mq[$];
    longint  stall_m = 0;
    int      errors = 0;
    int      checks = 0;

    imm_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal),
        .count(count), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference decode: immediate value assembled arithmetically, then wrapped to XLEN.
    function automatic entry_t ref_entry(input logic [31:0] ins, input logic [XLEN-1:0] pc);
        entry_t e;
        longint v;
        v     = 0;
        e.instr = ins;
        e.pc  = pc;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: begin
                e.fmt = 3'd1;
                if (ins[6:0] == 7'h13 && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5)) begin
                    v = (XLEN == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
                end else begin
                    v = longint'(ins[31:20]);
                    if (v >= 2048) v = v - 4096;
                end
            end
            7'h23: begin
                e.fmt = 3'd2;
                v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (v >= 2048) v = v - 4096;
            end
            7'h63: begin
                e.fmt = 3'd3;
                v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                  + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (ins[31]) v = v - 8192;
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd4;
                v = longint'(ins[31:12]) * 4096;
                if (ins[31]) v = v - (longint'(1) << 32);
            end
            7'h6f: begin
                e.fmt = 3'd5;
                v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                  + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                if (ins[31]) v = v - 2097152;
            end
            7'h33: e.fmt = 3'd0;
            default: e.ill = 1'b1;
        endcase
        e.imm = XLEN'(v);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                                  7'h37, 7'h17, 7'h6f, 7'h33, 7'h7f, 7'h00};
        logic [31:0] r;
        r = $urandom();
        return {r[31:7], ops[$urandom_range(0, 11)]};
    endfunction

    // Advance one clock and update the model from the inputs that were presented.
    task automatic cycle();
        bit     rdy, push, pop;
        entry_t e;
        rdy  = (mq.size() < DEPTH);
        push = in_valid && rdy;
        pop  = (mq.size() != 0) && out_ready;
        e    = ref_entry(in_instr, in_pc);
        if (in_valid && !rdy && !flush && stall_m != 64'hFFFF_FFFF) stall_m++;
        @(posedge clk);
        #1;
        if (flush) mq.delete();
        else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: count=%0d out_valid=%b in_ready=%b stall=%0d, want 0/0/1/0",
                     count, out_valid, in_ready, stall_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_imm_formats();
        logic [31:0] itab [6] = '{32'h00600113, 32'h12345037, 32'h4030D093,
                                  32'hFE512E23, 32'hFE000CE3, 32'h001000EF};
        longint      vtab [6] = '{6, 'h12345000, 3, -4, -8, 2048};
        logic [2:0]  ftab [6] = '{3'd1, 3'd4, 3'd1, 3'd2, 3'd3, 3'd5};
        logic [XLEN-1:0] ei;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_instr = itab[i];
            in_pc    = XLEN'(32'h1000 + 4 * i);
            cycle();
            in_valid = 1'b0;
            ei = XLEN'(vtab[i]);
            checks++;
            if (out_valid !== 1'b1 || out_imm !== ei || out_fmt !== ftab[i] ||
                out_illegal !== 1'b0 || out_instr !== itab[i]) begin
                errors++;
                $display("FAIL imm_format[%0d]: valid=%b imm=%h fmt=%0d ill=%b instr=%h, want 1 %h %0d 0 %h",
                         i, out_valid, out_imm, out_fmt, out_illegal, out_instr, ei, ftab[i], itab[i]);
            end
        end
        cycle();
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL imm_drain: count=%0d out_valid=%b, want 0 0", count, out_valid);
        end
    endtask

    task automatic test_fill_stall();
        entry_t e;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_instr = rand_instr();
            in_pc    = XLEN'($urandom());
            cycle();
        end
        checks++;
        if (in_ready !== 1'b0 || count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL fill_full: in_ready=%b count=%0d, want 0 %0d", in_ready, count, DEPTH);
        end
        for (int i = 0; i < 5; i++) begin
            in_instr = rand_instr();
            cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (stall_cnt !== (PERF ? 32'd5 : 32'd0) || count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL stall_count: stall=%0d count=%0d, want %0d %0d",
                     stall_cnt, count, PERF ? 5 : 0, DEPTH);
        end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            e = mq[0];
            checks++;
            if (out_valid !== 1'b1 || {out_instr, out_pc, out_imm, out_fmt, out_illegal} !==
                {e.instr, e.pc, e.imm, e.fmt, e.ill}) begin
                errors++;
                $display("FAIL fill_drain[%0d]: instr=%h imm=%h fmt=%0d ill=%b, want %h %h %0d %b",
                         i, out_instr, out_imm, out_fmt, out_illegal, e.instr, e.imm, e.fmt, e.ill);
            end
            cycle();
        end
        checks++;
        if (count !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fill_empty: count=%0d in_ready=%b, want 0 1", count, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        entry_t e;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_instr = rand_instr();
            in_pc    = XLEN'($urandom());
            cycle();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e = mq[0];
            checks++;
            if ({out_instr, out_pc, out_imm, out_fmt, out_illegal} !==
                {e.instr, e.pc, e.imm, e.fmt, e.ill}) begin
                errors++;
                $display("FAIL b2b_head[%0d]: instr=%h imm=%h, want %h %h",
                         i, out_instr, out_imm, e.instr, e.imm);
            end
            in_instr = rand_instr();
            in_pc    = XLEN'($urandom());
            cycle();
            checks++;
            if (count !== CW'(2)) begin
                errors++;
                $display("FAIL b2b_count[%0d]: count=%0d, want 2", i, count);
            end
        end
        in_valid = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instr = rand_instr();
            cycle();
        end
        checks++;
        if (count !== CW'(3)) begin
            errors++;
            $display("FAIL flush_pre: count=%0d, want 3", count);
        end
        flush    = 1'b1;
        in_instr = 32'h00500093;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: count=%0d out_valid=%b in_ready=%b, want 0 0 1",
                     count, out_valid, in_ready);
        end
        in_valid = 1'b1;
        in_instr = 32'h00700193;
        cycle();
        in_valid = 1'b0;
        checks++;
        if (count !== CW'(1) || out_instr !== 32'h00700193 || out_imm !== XLEN'(7)) begin
            errors++;
            $display("FAIL flush_after: count=%0d instr=%h imm=%h, want 1 00700193 7",
                     count, out_instr, out_imm);
        end
        out_ready = 1'b1;
        cycle();
    endtask

    task automatic test_illegal_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0000007F;
        cycle();
        checks++;
        if (out_illegal !== 1'b1 || out_fmt !== 3'd0 || out_imm !== '0) begin
            errors++;
            $display("FAIL illegal: ill=%b fmt=%0d imm=%h, want 1 0 0", out_illegal, out_fmt, out_imm);
        end
        for (int i = 0; i < 2; i++) begin
            in_instr = rand_instr();
            cycle();
        end
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        stall_m = 0;
        checks++;
        if (out_valid !== 1'b0 || count !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b count=%0d in_ready=%b, want 0 0 1",
                     out_valid, count, in_ready);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 32'd0 || count !== '0) begin
            errors++;
            $display("FAIL post_reset: stall=%0d count=%0d, want 0 0", stall_cnt, count);
        end
    endtask

    task automatic test_random();
        entry_t e;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_instr  = rand_instr();
            in_pc     = XLEN'($urandom());
            cycle();
            checks++;
            if (count !== CW'(mq.size()) || out_valid !== (mq.size() != 0) ||
                in_ready !== (mq.size() < DEPTH)) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: count=%0d valid=%b ready=%b, want count %0d",
                         i, count, out_valid, in_ready, mq.size());
            end
            checks++;
            if (stall_cnt !== (PERF ? 32'(stall_m) : 32'd0)) begin
                errors++;
                $display("FAIL rand_stall[%0d]: stall=%0d, want %0d", i, stall_cnt,
                         PERF ? stall_m : 0);
            end
            if (mq.size() != 0) begin
                e = mq[0];
                checks++;
                if ({out_instr, out_pc, out_imm, out_fmt, out_illegal} !==
                    {e.instr, e.pc, e.imm, e.fmt, e.ill}) begin
                    errors++;
                    $display("FAIL rand_head[%0d]: instr=%h pc=%h imm=%h fmt=%0d ill=%b, want %h %h %h %0d %b",
                             i, out_instr, out_pc, out_imm, out_fmt, out_illegal,
                             e.instr, e.pc, e.imm, e.fmt, e.ill);
                end
            end
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_imm_formats();
        test_fill_stall();
        test_back_to_back();
        test_flush();
        test_illegal_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_decode_queue.md
# imm_decode_queue

Instruction buffer between fetch and rename. It accepts raw 32-bit RV instructions with their PC over a valid/ready handshake. At enqueue it decodes the instruction format and the sign-extended XLEN-wide immediate, and stores both alongside the instruction in a DEPTH-entry FIFO. It presents the oldest entry to rename over a second valid/ready handshake and supports a single-cycle flush for mispredict recovery.

## Interface
- XLEN, 32, datapath width (32 or 64); immediates sign-extended to XLEN
- DEPTH, 4, FIFO entries, power of two, ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all entries
- in_valid  in  1  producer has an instruction
- in_ready  out  1  queue can accept
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_instr  out  32  head instruction
- out_pc  out  XLEN  head PC
- out_imm  out  XLEN  decoded immediate
- out_fmt  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J
- out_illegal  out  1  unrecognised opcode
- count  out  $clog2(DEPTH)+1  occupied entries
- stall_cnt  out  32  full-stall cycle counter (see Configuration)

## Operation
- Push on in_valid && in_ready; pop on out_valid && out_ready. Both may occur in the same cycle, and count is then unchanged.
- in_ready = (count < DEPTH). There is no bypass when full: a pop in the same cycle does not raise in_ready.
- out_valid = (count != 0). The out_* outputs are driven from the head entry. They are don't-care when out_valid=0 but must hold stable while out_valid && !out_ready.
- Decode is registered at push, from opcode bits [6:0]:
  - 0010011, 0000011, 1100111, 1110011 → I: sext(instr[31:20])
  - OP-IMM shifts (opcode 0010011 with funct3 001 or 101) → I: zero-extended shamt, instr[24:20] for XLEN=32, instr[25:20] for XLEN=64
  - 0100011 → S: sext({instr[31:25], instr[11:7]})
  - 1100011 → B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - 0110111, 0010111 → U: sext({instr[31:12], 12'b0})
  - 1101111 → J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - 0110011 → R: imm = 0
  - any other opcode → fmt=R, imm=0, out_illegal=1
- Read and write pointers are log2(DEPTH) bits and wrap naturally. count is kept separately and distinguishes full from empty.
- flush clears count and both pointers at the next edge. Flush overrides a push or pop in the same cycle; neither takes effect.

## Timing
- Reset (async assert, sync release): count=0, out_valid=0, in_ready=1, pointers=0, stall_cnt=0. Entry storage is not reset.
- Latency: an instruction pushed at edge N appears at the head at edge N (out_valid visible in cycle N+1 when the queue was empty). There is no combinational path from in_* to out_*.
- in_ready and out_valid depend only on registered count, never on in_valid or out_ready.
- Reset asserted mid-operation empties the queue immediately. Entries in flight are lost.

## Configuration
- IMM_QUEUE_PERF_EN defined: stall_cnt increments on every cycle with in_valid && !in_ready && !flush. It saturates at 0xFFFFFFFF and is cleared only by reset.
- IMM_QUEUE_PERF_EN undefined: stall_cnt is tied to 0 and no counter logic is built.

## Test plan
- Push 0x00600113, 0x12345037, 0x4030D093, each with out_ready=1. Required heads, in order:
  - imm=6, fmt=1
  - imm=0x12345000, fmt=4
  - imm=3, fmt=1
- Push 0xFE512E23, 0xFE000CE3, 0x001000EF. Required heads, in order:
  - imm=−4, fmt=2
  - imm=−8, fmt=3
  - imm=2048, fmt=5
  - For XLEN=64, negative immediates read 0xFFFF_FFFF_FFFF_FFFC and 0xFFFF_FFFF_FFFF_FFF8.
- Fill with out_ready=0 until full. Required: in_ready=0 after DEPTH pushes, count=DEPTH. Hold in_valid=1 for 5 more cycles; stall_cnt=5 with IMM_QUEUE_PERF_EN, 0 without. Drain with out_ready=1; entries emerge in order across pointer wrap.
- Hold in_valid=out_ready=1 continuously at count=2. Required: count stays 2 and the output order is preserved.
- Assert flush together with a push at count=3. Required: count=0 and out_valid=0 next cycle, and the pushed entry is discarded.
- Push 0x0000007F. Required: out_illegal=1, fmt=0, imm=0. Then assert rst_n=0 asynchronously mid-stream. Required: out_valid drops without waiting for a clock edge.
